store_buffer: RTL and testbench

- Write-back store queue between the MEM-stage load/store control and the data memory.
- Accepts stores in one cycle and holds them in an in-order FIFO.
- Drains the FIFO into the data memory on cycles when the memory port is not needed by a load.
- Forwards buffered store data to younger loads to the same address, so the pipeline sees sequentially consistent memory while store latency is hidden.

---
 rtl/store_buffer_pkg.sv | 15 +
 rtl/store_buffer_if.sv | 28 ++
 rtl/store_buffer_forward_match.sv | 32 +++
 rtl/store_buffer.sv | 99 +++++++++
 tb/tb_store_buffer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared widths, entry type and memory-port encodings for the store buffer.
package store_buffer_pkg;

   localparam int SB_WIDTH = 32;
   localparam int SB_DEPTH = 4;

   typedef struct packed {
      logic [SB_WIDTH-1:0] addr;
      logic [SB_WIDTH-1:0] data;
   } sb_entry_t;

   localparam logic MEM_WRITE = 1'b1;
   localparam logic MEM_READ  = 1'b0;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side and data-memory-side signals of the store buffer.
interface store_buffer_if;
   import store_buffer_pkg::*;

   logic                st_valid;
   logic                ld_valid;
   logic                flush_req;
   logic [SB_WIDTH-1:0] address;
   logic [SB_WIDTH-1:0] write_data;
   logic [SB_WIDTH-1:0] ld_data;
   logic                stall;
   logic                empty;
   logic [SB_WIDTH-1:0] mem_address;
   logic                mem_write_read;
   logic [SB_WIDTH-1:0] mem_write_data;
   logic [SB_WIDTH-1:0] mem_read_data;

   modport master (
      output st_valid, ld_valid, flush_req, address, write_data, mem_read_data,
      input  ld_data, stall, empty, mem_address, mem_write_read, mem_write_data
   );

   modport slave (
      input  st_valid, ld_valid, flush_req, address, write_data, mem_read_data,
      output ld_data, stall, empty, mem_address, mem_write_read, mem_write_data
   );

endinterface

// File: rtl/store_buffer_forward_match.sv
// Age-priority address matcher: returns data of the youngest valid entry whose address matches.
module sb_forward_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  sb_entry_t           entries_i [DEPTH],
   input  logic [DEPTH-1:0]    valid_i,
   input  logic [PTR_W-1:0]    head_i,
   input  logic [SB_WIDTH-1:0] addr_i,
   output logic                hit_o,
   output logic [SB_WIDTH-1:0] data_o
);

   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i + PTR_W'(k);
         if (valid_i[idx] && (entries_i[idx].addr == addr_i)) begin
            hit_o  = 1'b1;
            data_o = entries_i[idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Write-back store queue: in-order FIFO drained on load-free cycles, with load forwarding.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   store_buffer_if.slave bus
);

   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   sb_entry_t           entries_q [DEPTH];
   sb_entry_t           head_entry;
   logic [PTR_W-1:0]    head_q, head_d;
   logic [PTR_W-1:0]    tail_q, tail_d;
   logic [PTR_W:0]      count_q, count_d;
   logic [DEPTH-1:0]    valid;
   logic [PTR_W-1:0]    off;
   logic                not_empty, full, stall;
   logic                st_eff, ld_eff, drain;
   logic                fwd_hit;
   logic [SB_WIDTH-1:0] fwd_data;

   assign not_empty  = (count_q != '0);
   assign full       = (count_q == CNT_FULL);
   assign stall      = (bus.st_valid & full) |
                       (bus.flush_req & not_empty & (bus.st_valid | bus.ld_valid));
   assign st_eff     = bus.st_valid & ~stall;
   // A store+load collision is handled as a store, so it never blocks the drain.
   assign ld_eff     = bus.ld_valid & ~bus.st_valid & ~stall;
   assign drain      = ~ld_eff & not_empty;
   assign head_entry = entries_q[head_q];

   always_comb begin
      valid = '0;
      off   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off      = PTR_W'(i) - head_q;
         valid[i] = ({1'b0, off} < count_q);
      end
   end

   sb_forward_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_forward (
      .entries_i (entries_q),
      .valid_i   (valid),
      .head_i    (head_q),
      .addr_i    (bus.address),
      .hit_o     (fwd_hit),
      .data_o    (fwd_data)
   );

   always_comb begin
      bus.mem_write_read = MEM_READ;
      bus.mem_address    = bus.address;
      bus.mem_write_data = '0;
      if (drain) begin
         bus.mem_write_read = MEM_WRITE;
         bus.mem_address    = head_entry.addr;
         bus.mem_write_data = head_entry.data;
      end
   end

   assign bus.ld_data = (bus.st_valid & bus.ld_valid) ? '0 :
                        fwd_hit                       ? fwd_data : bus.mem_read_data;
   assign bus.stall   = stall;
   assign bus.empty   = ~not_empty;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      if (drain)  head_d = head_q + 1'b1;
      if (st_eff) tail_d = tail_q + 1'b1;
      count_d = count_q + (PTR_W+1)'(st_eff) - (PTR_W+1)'(drain);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload needs no reset: count gates every read of it.
   always_ff @(posedge clk_i) begin
      if (st_eff) entries_q[tail_q] <= '{addr: bus.address, data: bus.write_data};
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random stimulus against a program-order memory model of the store buffer.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int MEMW = 256;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } st_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_buffer_if bus();

   store_buffer dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   logic [31:0] dmem [MEMW];
   logic [31:0] arch [MEMW];
   st_t         sbq[$];
   int          n_assert = 0;
   int          n_fail   = 0;

   assign bus.mem_read_data = dmem[bus.mem_address[7:0]];

   always @(posedge clk) begin
      if (bus.mem_write_read) dmem[bus.mem_address[7:0]] <= bus.mem_write_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One pipeline cycle: drive, check combinational outputs against the model, clock, update model.
   task automatic step(input logic st, input logic ld, input logic [31:0] a,
                       input logic [31:0] wd, input logic fl);
      int   n;
      logic exp_stall, ld_eff, exp_drain;
      @(negedge clk);
      bus.st_valid   = st;
      bus.ld_valid   = ld;
      bus.address    = a;
      bus.write_data = wd;
      bus.flush_req  = fl;
      #2;
      n         = sbq.size();
      exp_stall = (st && n == SB_DEPTH) || (fl && n != 0 && (st || ld));
      ld_eff    = ld && !st && !exp_stall;
      exp_drain = !ld_eff && n != 0;
      chk("stall", {31'b0, bus.stall}, {31'b0, exp_stall});
      chk("empty", {31'b0, bus.empty}, {31'b0, n == 0});
      chk("mem_wr", {31'b0, bus.mem_write_read}, {31'b0, exp_drain});
      if (exp_drain) begin
         chk("drain_addr", bus.mem_address, sbq[0].addr);
         chk("drain_data", bus.mem_write_data, sbq[0].data);
      end else begin
         chk("mem_addr", bus.mem_address, a);
         chk("mem_wdata", bus.mem_write_data, 32'h0);
      end
      if (ld_eff)   chk("ld_data", bus.ld_data, arch[a[7:0]]);
      if (st && ld) chk("ld_data_illegal", bus.ld_data, 32'h0);
      @(posedge clk);
      if (exp_drain) void'(sbq.pop_front());
      if (st && !exp_stall) begin
         sbq.push_back('{addr: a, data: wd});
         arch[a[7:0]] = wd;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0000_0050 + 32'(i), 32'h0, 1'b0);
   endtask

   initial begin
      logic [31:0] a, d;
      int          op, guard;
      bus.st_valid = 1'b0; bus.ld_valid = 1'b0; bus.flush_req = 1'b0;
      bus.address = '0; bus.write_data = '0;
      for (int i = 0; i < MEMW; i++) begin
         dmem[i] = 32'h5000_0000 + 32'(i);
         arch[i] = dmem[i];
      end
      #12 rst_n = 1'b1;

      idle(10);
      step(1'b0, 1'b1, 32'h50, 32'h0, 1'b0);

      step(1'b1, 1'b0, 32'h10, 32'hAAAA_0001, 1'b0);
      idle(2);
      chk("mem10", dmem[8'h10], 32'hAAAA_0001);
      chk("empty_after_drain", {31'b0, bus.empty}, 32'h1);

      step(1'b1, 1'b0, 32'h20, 32'h1, 1'b0);
      step(1'b1, 1'b0, 32'h20, 32'h2, 1'b0);
      step(1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
      chk("fwd_youngest", bus.ld_data, 32'h2);
      idle(2);
      chk("mem20", dmem[8'h20], 32'h2);

      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 32'h40 + 32'(4*i), 32'hC000_0000 + 32'(i), 1'b0);
         step(1'b0, 1'b1, 32'h40 + 32'(4*i), 32'h0, 1'b0);
      end
      step(1'b1, 1'b0, 32'h40, 32'hC0C0_0040, 1'b0);
      step(1'b0, 1'b1, 32'h30, 32'h0, 1'b0);
      chk("no_fwd", bus.ld_data, 32'h5000_0030);
      idle(2);

      step(1'b1, 1'b0, 32'h44, 32'hF1F1_0044, 1'b0);
      step(1'b0, 1'b1, 32'h44, 32'h0, 1'b1);
      step(1'b0, 1'b1, 32'h44, 32'h0, 1'b1);
      chk("flush_ld", bus.ld_data, 32'hF1F1_0044);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      step(1'b1, 1'b1, 32'h48, 32'h1234_5678, 1'b0);
      idle(1);

      step(1'b1, 1'b0, 32'h60, 32'hDEAD_0060, 1'b0);
      @(negedge clk);
      bus.st_valid = 1'b0; bus.ld_valid = 1'b0; bus.flush_req = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_empty", {31'b0, bus.empty}, 32'h1);
      chk("rst_no_wr", {31'b0, bus.mem_write_read}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      sbq.delete();
      for (int i = 0; i < MEMW; i++) arch[i] = dmem[i];
      idle(3);
      chk("rst_discard", dmem[8'h60], 32'h5000_0060);

      for (int i = 0; i < 400; i++) begin
         op = int'($urandom_range(0, 9));
         a  = 32'h10 + 32'(4 * $urandom_range(0, 7));
         d  = $urandom;
         if (op < 4)      step(1'b1, 1'b0, a, d, $urandom_range(0, 9) == 0);
         else if (op < 7) step(1'b0, 1'b1, a, 32'h0, $urandom_range(0, 9) == 0);
         else             step(1'b0, 1'b0, a, 32'h0, $urandom_range(0, 4) == 0);
      end

      guard = 0;
      while (sbq.size() != 0 && guard < 10) begin
         step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
         guard++;
      end
      chk("final_drain_bound", 32'(sbq.size()), 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int i = 16; i < 48; i += 4) chk("final_mem", dmem[i], arch[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
